// File: rtl/abr_params_pkg.sv
// Shared memory-interface types and sizing for the ABR memory responder.
// Holds the request encodings, the request struct and the responder FSM states.
package abr_params_pkg;

   localparam int unsigned MLDSA_K            = 8;
   localparam int unsigned MLDSA_N            = 256;
   localparam int unsigned ABR_MEM_DEPTH      = MLDSA_K * (MLDSA_N / 4) * 2;
   localparam int unsigned ABR_MEM_ADDR_WIDTH = 15;
   localparam int unsigned ABR_MEM_DATA_WIDTH = 96;

   typedef enum logic [1:0] {
      RW_IDLE  = 2'b00,
      RW_READ  = 2'b01,
      RW_WRITE = 2'b10
   } rw_op_e;

   typedef struct packed {
      rw_op_e                        rd_wr_en;
      logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
   } mem_if_t;

   typedef enum logic {
      RSP_ACTIVE = 1'b0,
      RSP_WIPE   = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/abr_mem_responder.sv
// Front-end for an external 1R1W SRAM: range/protocol checking, write-first
// read bypass, registered response flags and a full zeroize sweep.
module abr_mem_responder
   import abr_params_pkg::*;
#(
   parameter int unsigned DEPTH  = ABR_MEM_DEPTH,
   parameter int unsigned DATA_W = ABR_MEM_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          zeroize,
   input  mem_if_t                       rd_req,
   input  mem_if_t                       wr_req,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_valid,
   output logic                          sram_rd_en,
   output logic                          sram_wr_en,
   output logic [ABR_MEM_ADDR_WIDTH-1:0] sram_rd_addr,
   output logic [ABR_MEM_ADDR_WIDTH-1:0] sram_wr_addr,
   output logic [DATA_W-1:0]             sram_wdata,
   input  logic [DATA_W-1:0]             sram_rdata,
   output logic                          busy,
   output logic                          addr_err,
   output logic                          proto_err,
   output logic                          req_drop
);

   localparam int unsigned       AW        = ABR_MEM_ADDR_WIDTH;
   localparam logic [AW:0]       DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]     WIPE_LAST = AW'(DEPTH - 1);

   rsp_state_e          state, state_nxt;
   logic [AW-1:0]       wipe_cnt, wipe_cnt_nxt;

   logic                accept;
   logic                rd_ok, rd_oor, wr_ok, wr_oor;
   logic                proto_hit, drop_hit, bypass_hit;
   logic                rd_oor_q, bypass_q;
   logic [DATA_W-1:0]   bypass_data_q;

   // Requests are only honoured in ACTIVE and never in the cycle zeroize is seen
   always_comb begin
      accept     = (state == RSP_ACTIVE) && !zeroize;
      rd_ok      = accept && (rd_req.rd_wr_en == RW_READ)  && ({1'b0, rd_req.addr} <  DEPTH_EXT);
      rd_oor     = accept && (rd_req.rd_wr_en == RW_READ)  && ({1'b0, rd_req.addr} >= DEPTH_EXT);
      wr_ok      = accept && (wr_req.rd_wr_en == RW_WRITE) && ({1'b0, wr_req.addr} <  DEPTH_EXT);
      wr_oor     = accept && (wr_req.rd_wr_en == RW_WRITE) && ({1'b0, wr_req.addr} >= DEPTH_EXT);
      proto_hit  = accept &&
                   (((rd_req.rd_wr_en != RW_IDLE) && (rd_req.rd_wr_en != RW_READ)) ||
                    ((wr_req.rd_wr_en != RW_IDLE) && (wr_req.rd_wr_en != RW_WRITE)));
      drop_hit   = !accept && ((rd_req.rd_wr_en != RW_IDLE) || (wr_req.rd_wr_en != RW_IDLE));
      bypass_hit = rd_ok && wr_ok && (rd_req.addr == wr_req.addr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RSP_ACTIVE;
         wipe_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wipe_cnt <= wipe_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wipe_cnt_nxt = wipe_cnt;
      case (state)
         RSP_ACTIVE: begin
            if (zeroize) begin
               state_nxt    = RSP_WIPE;
               wipe_cnt_nxt = '0;
            end
         end
         RSP_WIPE: begin
            if (zeroize) begin
               wipe_cnt_nxt = '0;
            end else if (wipe_cnt == WIPE_LAST) begin
               state_nxt    = RSP_ACTIVE;
               wipe_cnt_nxt = '0;
            end else begin
               wipe_cnt_nxt = wipe_cnt + AW'(1);
            end
         end
      endcase
   end

   always_comb begin
      busy         = (state == RSP_WIPE);
      sram_rd_en   = 1'b0;
      sram_rd_addr = '0;
      sram_wr_en   = 1'b0;
      sram_wr_addr = '0;
      sram_wdata   = '0;
      if (busy) begin
         sram_wr_en   = 1'b1;
         sram_wr_addr = wipe_cnt;
      end else if (wr_ok) begin
         sram_wr_en   = 1'b1;
         sram_wr_addr = wr_req.addr;
         sram_wdata   = wr_data;
      end
      if (rd_ok) begin
         sram_rd_en   = 1'b1;
         sram_rd_addr = rd_req.addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid      <= 1'b0;
         rd_oor_q      <= 1'b0;
         bypass_q      <= 1'b0;
         bypass_data_q <= '0;
         addr_err      <= 1'b0;
         proto_err     <= 1'b0;
         req_drop      <= 1'b0;
      end else begin
         rd_valid  <= rd_ok || rd_oor;
         rd_oor_q  <= rd_oor;
         bypass_q  <= bypass_hit;
         if (bypass_hit) begin
            bypass_data_q <= wr_data;
         end
         addr_err  <= rd_oor || wr_oor;
         proto_err <= proto_hit;
         req_drop  <= drop_hit;
      end
   end

   // SRAM read returns the pre-write word on a collision, so the bypass copy wins
   always_comb begin
      rd_data = '0;
      if (rd_valid && !rd_oor_q) begin
         rd_data = bypass_q ? bypass_data_q : sram_rdata;
      end
   end

endmodule

// File: tb/tb_abr_mem_responder.sv
// Directed self-checking bench for abr_mem_responder with a behavioural 1R1W SRAM.
module tb_abr_mem_responder;
   import abr_params_pkg::*;

   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned DATA_W = 96;
   localparam int unsigned AW     = ABR_MEM_ADDR_WIDTH;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              zeroize;
   mem_if_t           rd_req, wr_req;
   logic [DATA_W-1:0] wr_data, rd_data, sram_wdata, sram_rdata;
   logic              rd_valid, sram_rd_en, sram_wr_en, busy, addr_err, proto_err, req_drop;
   logic [AW-1:0]     sram_rd_addr, sram_wr_addr;

   int checks = 0;
   int errors = 0;

   abr_mem_responder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
      .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
      .sram_rd_addr(sram_rd_addr), .sram_wr_addr(sram_wr_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .busy(busy), .addr_err(addr_err), .proto_err(proto_err), .req_drop(req_drop)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (sram_wr_en) mem[sram_wr_addr[9:0]] <= sram_wdata;
      if (sram_rd_en) sram_rdata <= mem[sram_rd_addr[9:0]];
   end

   function automatic logic [DATA_W-1:0] pat(input int unsigned i);
      return {32'hA000_0000 | i, ~i, i * 32'd7};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rd_req.rd_wr_en = RW_IDLE; rd_req.addr = '0;
      wr_req.rd_wr_en = RW_IDLE; wr_req.addr = '0;
      wr_data = '0;
      zeroize = 1'b0;
   endtask

   task automatic drive_rd(input rw_op_e op, input int unsigned a);
      rd_req.rd_wr_en = op; rd_req.addr = AW'(a);
   endtask

   task automatic drive_wr(input rw_op_e op, input int unsigned a, input logic [DATA_W-1:0] d);
      wr_req.rd_wr_en = op; wr_req.addr = AW'(a); wr_data = d;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({addr_err, proto_err, req_drop} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {addr_err, proto_err, req_drop}); end
      checks++; if ({sram_rd_en, sram_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_sram_en: got %b expected 00", {sram_rd_en, sram_wr_en}); end
      @(negedge clk) reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      drive_wr(RW_WRITE, 5, 96'hA5);
      #1;
      checks++; if ({sram_wr_en, sram_wr_addr, sram_wdata} !== {1'b1, AW'(5), 96'hA5}) begin errors++;
         $display("FAIL wr_passthru: got en=%b addr=%0d data=%h expected en=1 addr=5 data=a5", sram_wr_en, sram_wr_addr, sram_wdata); end
      tick();
      drive_wr(RW_IDLE, 0, '0);
      drive_rd(RW_READ, 5);
      #1;
      checks++; if ({sram_rd_en, sram_rd_addr} !== {1'b1, AW'(5)}) begin errors++;
         $display("FAIL rd_passthru: got en=%b addr=%0d expected en=1 addr=5", sram_rd_en, sram_rd_addr); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %b expected 0", rd_valid); end
      tick();
      drive_rd(RW_IDLE, 0);
      checks++; if ({rd_valid, rd_data} !== {1'b1, 96'hA5}) begin errors++;
         $display("FAIL rd_after_wr: got valid=%b data=%h expected valid=1 data=a5", rd_valid, rd_data); end
      tick();
      checks++; if ({rd_valid, rd_data} !== {1'b0, 96'h0}) begin errors++;
         $display("FAIL rd_valid_pulse: got valid=%b data=%h expected valid=0 data=0", rd_valid, rd_data); end
   endtask

   task automatic test_bypass();
      drive_wr(RW_WRITE, 7, 96'h11);
      tick();
      drive_wr(RW_WRITE, 7, 96'h3C);
      drive_rd(RW_READ, 7);
      #1;
      checks++; if ({sram_rd_en, sram_wr_en} !== 2'b11) begin errors++; $display("FAIL bypass_sram_en: got %b expected 11", {sram_rd_en, sram_wr_en}); end
      tick();
      drive_wr(RW_WRITE, 8, 96'h77);
      drive_rd(RW_READ, 5);
      checks++; if ({rd_valid, rd_data} !== {1'b1, 96'h3C}) begin errors++;
         $display("FAIL bypass_data: got valid=%b data=%h expected valid=1 data=3c", rd_valid, rd_data); end
      tick();
      drive_wr(RW_IDLE, 0, '0);
      drive_rd(RW_READ, 7);
      checks++; if ({rd_valid, rd_data} !== {1'b1, 96'hA5}) begin errors++;
         $display("FAIL diff_addr_no_bypass: got valid=%b data=%h expected valid=1 data=a5", rd_valid, rd_data); end
      tick();
      drive_rd(RW_IDLE, 0);
      checks++; if ({rd_valid, rd_data} !== {1'b1, 96'h3C}) begin errors++;
         $display("FAIL bypass_wrote_sram: got valid=%b data=%h expected valid=1 data=3c", rd_valid, rd_data); end
      tick();
   endtask

   task automatic test_addr_range();
      drive_rd(RW_READ, 1024);
      #1;
      checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL oor_rd_en: got %b expected 0", sram_rd_en); end
      tick();
      drive_rd(RW_IDLE, 0);
      checks++; if ({rd_valid, addr_err, rd_data} !== {2'b11, 96'h0}) begin errors++;
         $display("FAIL oor_rd_resp: got valid=%b err=%b data=%h expected 1 1 0", rd_valid, addr_err, rd_data); end
      tick();
      checks++; if ({rd_valid, addr_err} !== 2'b00) begin errors++; $display("FAIL oor_pulse: got %b expected 00", {rd_valid, addr_err}); end
      drive_rd(RW_READ, 1500);
      drive_wr(RW_WRITE, 2000, 96'hFF);
      #1;
      checks++; if ({sram_rd_en, sram_wr_en} !== 2'b00) begin errors++; $display("FAIL oor_both_en: got %b expected 00", {sram_rd_en, sram_wr_en}); end
      tick();
      drive_rd(RW_IDLE, 0);
      drive_wr(RW_WRITE, 1024, 96'hFF);
      checks++; if ({addr_err, rd_valid} !== 2'b11) begin errors++; $display("FAIL oor_both_resp: got err,valid=%b expected 11", {addr_err, rd_valid}); end
      tick();
      drive_wr(RW_IDLE, 0, '0);
      checks++; if ({addr_err, rd_valid} !== 2'b10) begin errors++; $display("FAIL oor_wr_resp: got err,valid=%b expected 10", {addr_err, rd_valid}); end
      tick();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_single_pulse: got %b expected 0", addr_err); end
      drive_wr(RW_WRITE, 1023, 96'hBEEF);
      tick();
      drive_wr(RW_IDLE, 0, '0);
      drive_rd(RW_READ, 1023);
      tick();
      drive_rd(RW_IDLE, 0);
      checks++; if ({rd_valid, addr_err, rd_data} !== {2'b10, 96'hBEEF}) begin errors++;
         $display("FAIL last_addr: got valid=%b err=%b data=%h expected 1 0 beef", rd_valid, addr_err, rd_data); end
      tick();
   endtask

   task automatic test_proto();
      drive_rd(RW_WRITE, 2);
      #1;
      checks++; if ({sram_rd_en, sram_wr_en} !== 2'b00) begin errors++; $display("FAIL proto_rd_en: got %b expected 00", {sram_rd_en, sram_wr_en}); end
      tick();
      drive_rd(RW_IDLE, 0);
      drive_wr(RW_READ, 4, 96'h1);
      #1;
      checks++; if ({proto_err, rd_valid, addr_err} !== 3'b100) begin errors++; $display("FAIL proto_rd_port: got perr,valid,aerr=%b expected 100", {proto_err, rd_valid, addr_err}); end
      checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL proto_wr_en: got %b expected 0", sram_wr_en); end
      tick();
      drive_idle();
      rd_req.addr = AW'(2000);
      wr_req.addr = AW'(3000);
      checks++; if ({proto_err, rd_valid} !== 2'b10) begin errors++; $display("FAIL proto_wr_port: got perr,valid=%b expected 10", {proto_err, rd_valid}); end
      tick();
      checks++; if ({proto_err, addr_err, req_drop, rd_valid} !== 4'b0000) begin errors++;
         $display("FAIL idle_no_flag: got %b expected 0000", {proto_err, addr_err, req_drop, rd_valid}); end
      drive_idle();
   endtask

   task automatic test_zeroize();
      int n;
      drive_wr(RW_WRITE, 3, 96'h5555);
      tick();
      drive_wr(RW_IDLE, 0, '0);
      zeroize = 1'b1;
      drive_rd(RW_READ, 3);
      #1;
      checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL zcycle_rd_en: got %b expected 0", sram_rd_en); end
      tick();
      zeroize = 1'b0;
      checks++; if ({req_drop, rd_valid, busy} !== 3'b101) begin errors++; $display("FAIL zcycle_drop: got drop,valid,busy=%b expected 101", {req_drop, rd_valid, busy}); end
      checks++; if ({sram_wr_en, sram_wr_addr, sram_wdata} !== {1'b1, AW'(0), 96'h0}) begin errors++;
         $display("FAIL wipe_first: got en=%b addr=%0d data=%h expected 1 0 0", sram_wr_en, sram_wr_addr, sram_wdata); end
      n = 1;
      tick();
      drive_idle();
      checks++; if ({req_drop, rd_valid} !== 2'b10) begin errors++; $display("FAIL wipe_drop: got drop,valid=%b expected 10", {req_drop, rd_valid}); end
      while (busy === 1'b1 && n < 3000) begin
         checks++; if (sram_wr_addr !== AW'(n)) begin errors++; $display("FAIL wipe_addr: got %0d expected %0d", sram_wr_addr, n); end
         n++;
         tick();
      end
      checks++; if (n != 1024) begin errors++; $display("FAIL busy_len: got %0d expected 1024", n); end
      checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL wipe_end_wr_en: got %b expected 0", sram_wr_en); end
      drive_rd(RW_READ, 3);
      tick();
      drive_rd(RW_IDLE, 0);
      checks++; if ({rd_valid, rd_data} !== {1'b1, 96'h0}) begin errors++;
         $display("FAIL wiped_data: got valid=%b data=%h expected 1 0", rd_valid, rd_data); end
      tick();
   endtask

   task automatic test_zeroize_restart();
      int n;
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      repeat (5) tick();
      checks++; if (sram_wr_addr !== AW'(5)) begin errors++; $display("FAIL restart_pre: got %0d expected 5", sram_wr_addr); end
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      checks++; if ({busy, sram_wr_addr} !== {1'b1, AW'(0)}) begin errors++;
         $display("FAIL restart_cnt: got busy=%b addr=%0d expected 1 0", busy, sram_wr_addr); end
      n = 0;
      while (busy === 1'b1 && n < 3000) begin n++; tick(); end
      checks++; if (n != 1024) begin errors++; $display("FAIL restart_len: got %0d expected 1024", n); end
   endtask

   task automatic test_reset_mid_wipe();
      int k;
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      k = 0;
      while (sram_wr_addr !== AW'(200) && k < 500) begin k++; tick(); end
      checks++; if (k != 200) begin errors++; $display("FAIL wipe_reach_200: got %0d cycles expected 200", k); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({busy, sram_wr_en, sram_rd_en, rd_valid, addr_err, proto_err, req_drop} !== 7'b0) begin errors++;
         $display("FAIL reset_mid_wipe: got %b expected 0000000", {busy, sram_wr_en, sram_rd_en, rd_valid, addr_err, proto_err, req_drop}); end
      checks++; if (sram_wr_addr !== '0 || rd_data !== '0) begin errors++;
         $display("FAIL reset_mid_wipe_bus: got addr=%0d data=%h expected 0 0", sram_wr_addr, rd_data); end
      @(negedge clk) reset_n = 1'b1;
      tick();
      drive_rd(RW_READ, 1);
      #1;
      checks++; if ({busy, sram_rd_en} !== 2'b01) begin errors++; $display("FAIL post_reset_active: got busy,rd_en=%b expected 01", {busy, sram_rd_en}); end
      tick();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got %b expected 1", rd_valid); end
      drive_idle();
      #1 reset_n = 1'b0;
      #1;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset: got %b expected 0", rd_valid); end
      @(negedge clk) reset_n = 1'b1;
      tick();
      checks++; if ({rd_valid, rd_data} !== {1'b0, 96'h0}) begin errors++;
         $display("FAIL inflight_after: got valid=%b data=%h expected 0 0", rd_valid, rd_data); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 512; i++) begin
         drive_wr(RW_WRITE, i, pat(i));
         tick();
      end
      drive_wr(RW_IDLE, 0, '0);
      for (int i = 0; i < 512; i++) begin
         drive_rd(RW_READ, i);
         tick();
         checks++; if ({rd_valid, rd_data} !== {1'b1, pat(i)}) begin errors++;
            $display("FAIL stream_%0d: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, pat(i)); end
      end
      drive_rd(RW_IDLE, 0);
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b expected 0", rd_valid); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_addr_range();
      test_proto();
      test_zeroize();
      test_zeroize_restart();
      test_reset_mid_wipe();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/abr_mem_responder.md
ABR_MEM_RESPONDER -- requirements
Module: abr_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, giving the number of words served; addresses 0..DEPTH-1 are valid.
REQ-002 The module SHALL have parameter DATA_W, default 96, giving the word width (4 coefficients x 24 bits).
REQ-003 clk  input  1  clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-004 zeroize  input  1  synchronous wipe request, pulse.
REQ-005 rd_req  input  mem_if_t  read-port request (rd_wr_en, addr[ABR_MEM_ADDR_WIDTH]).
REQ-006 wr_req  input  mem_if_t  write-port request.
REQ-007 wr_data  input  DATA_W  write data, qualified by wr_req.rd_wr_en==RW_WRITE.
REQ-008 rd_data  output  DATA_W  read data; rd_valid  output  1  rd_data qualifier.
REQ-009 sram_rd_en, sram_wr_en  output  1 each; sram_rd_addr, sram_wr_addr  output  ABR_MEM_ADDR_WIDTH; sram_wdata  output  DATA_W; sram_rdata  input  DATA_W (1R1W SRAM, 1-cycle read latency).
REQ-010 busy  output  1  wipe in progress; addr_err  output  1  range-error pulse; proto_err  output  1  illegal-op pulse; req_drop  output  1  request-dropped pulse.

Function
REQ-011 FSM states SHALL be RSP_ACTIVE and RSP_WIPE; reset state RSP_ACTIVE.
REQ-012 RSP_ACTIVE -> RSP_WIPE when zeroize=1; RSP_WIPE -> RSP_ACTIVE the cycle after wipe_cnt==DEPTH-1 is written; zeroize in RSP_WIPE SHALL restart wipe_cnt at 0.
REQ-013 In RSP_WIPE the block SHALL drive sram_wr_en=1, sram_wr_addr=wipe_cnt, sram_wdata=0 every cycle, wipe_cnt incrementing 0..DEPTH-1; busy=1 for exactly DEPTH cycles.
REQ-014 In RSP_ACTIVE, rd_req.rd_wr_en==RW_READ with addr<DEPTH SHALL drive sram_rd_en=1, sram_rd_addr=addr the same cycle (combinational pass-through).
REQ-015 In RSP_ACTIVE, wr_req.rd_wr_en==RW_WRITE with addr<DEPTH SHALL drive sram_wr_en=1, sram_wr_addr=addr, sram_wdata=wr_data the same cycle.
REQ-016 A read accepted in cycle N SHALL produce rd_valid=1 in cycle N+1 with rd_data=sram_rdata; one read per cycle, fully pipelined, no backpressure.
REQ-017 Same-cycle read and write to the same valid address SHALL be write-first: rd_data in N+1 equals the wr_data of cycle N (bypass register), not sram_rdata.
REQ-018 Read with addr>=DEPTH: no SRAM access; rd_valid=1 in N+1 with rd_data=0; addr_err=1 in N+1.
REQ-019 Write with addr>=DEPTH: no SRAM access; addr_err=1 in N+1; both ports out of range same cycle -> single addr_err pulse.
REQ-020 rd_req.rd_wr_en==RW_WRITE or wr_req.rd_wr_en==RW_READ SHALL be ignored (no SRAM access, no rd_valid) and set proto_err=1 in N+1.
REQ-021 Any RW_READ/RW_WRITE request arriving in RSP_WIPE, or in the zeroize cycle, SHALL be dropped with req_drop=1 in N+1 and no rd_valid.
REQ-022 RW_IDLE on either port SHALL produce no SRAM access and no flag; addr is don't-care.
REQ-023 rd_valid, addr_err, proto_err, req_drop SHALL be registered single-cycle pulses; rd_data SHALL be 0 when rd_valid=0.

Reset
REQ-024 On reset_n low: state RSP_ACTIVE, wipe_cnt=0, bypass register 0, all outputs 0 (rd_data=0, rd_valid=0, busy=0, all flags 0, all SRAM enables 0).
REQ-025 Reset asserted mid-wipe SHALL abort the wipe; SRAM contents are then unspecified until next zeroize.
REQ-026 A read in flight when reset asserts SHALL not produce rd_valid after reset release.

Structure
REQ-027 Enum rsp_state_e (RSP_ACTIVE, RSP_WIPE) SHALL live in abr_params_pkg next to mem_if_t and the RW_* encodings; DEPTH default derives from MLDSA_K*(MLDSA_N/4)*2.
REQ-028 Single module, no sub-modules; SRAM instantiated outside.

Verification
REQ-029 Write addr 5 data 0xA5 (cycle 0), read addr 5 (cycle 1) -> rd_valid cycle 2, rd_data=0xA5.
REQ-030 Same cycle: write addr 7 data 0x3C, read addr 7 -> next cycle rd_data=0x3C, rd_valid=1, sram_rd_en still 1.
REQ-031 Read addr 1024 (DEPTH=1024) -> next cycle rd_valid=1, rd_data=0, addr_err=1, sram_rd_en=0.
REQ-032 zeroize pulse, read addr 3 during wipe -> busy=1 for 1024 cycles, req_drop=1, no rd_valid; after wipe read addr 3 -> rd_data=0.
REQ-033 rd_req with RW_WRITE -> proto_err=1 next cycle, no SRAM enable; reset_n low at wipe_cnt=200 -> all outputs 0, state RSP_ACTIVE.
REQ-034 Stream 512 back-to-back reads addr 0..511 -> 512 consecutive rd_valid cycles, each rd_data matching the SRAM model.
